// File: rtl/bicubic_y_coord_gen.sv
// Vertical source-position generator for the bicubic Y-weight stage.
// Emits one row of {yBlend, clamped taps, coefficients} per valid/ready handshake.
module bicubic_y_coord_gen #(
  parameter int ROW_W  = 11,
  parameter int STEP_W = 19,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [STEP_W-1:0] step,
  input  logic [ROW_W-1:0]  src_h,
  input  logic [ROW_W-1:0]  dst_h,
  input  logic [8:0]        a_cfg,
  output logic              row_valid,
  input  logic              row_ready,
  output logic [8:0]        yBlend,
  output logic [ROW_W-1:0]  tap_m1,
  output logic [ROW_W-1:0]  tap_0,
  output logic [ROW_W-1:0]  tap_p1,
  output logic [ROW_W-1:0]  tap_p2,
  output logic [8:0]        coeffOne,
  output logic [8:0]        coeffHalf,
  output logic [8:0]        bi_a,
  output logic              frame_done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic signed [ACC_W-1:0] ONE = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] TWO = ACC_W'(2);

  state_t                   state, state_nx;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_init;
  logic signed [ACC_W-1:0]  step_ext;
  logic [ROW_W-1:0]         cnt;
  logic [ROW_W-1:0]         src_q;
  logic [ROW_W-1:0]         dst_q;
  logic [STEP_W-1:0]        step_q;
  logic [8:0]               a_q;
  logic                     done_q;
  logic                     hs;
  logic                     last;
  logic                     start_run;

  // Centre alignment: first row sits at step/2 - 0.5 source rows.
  assign acc_init  = ACC_W'(step >> 1) - ACC_W'(128);
  assign step_ext  = ACC_W'(step_q);
  assign hs        = (state == RUN) && row_ready;
  assign last      = (cnt == dst_q - 1'b1);
  assign start_run = frame_start && (dst_h != '0);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start_run) state_nx = RUN;
      RUN: begin
        if (frame_start)    state_nx = start_run ? RUN : IDLE;
        else if (hs && last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      src_q  <= '0;
      dst_q  <= '0;
      step_q <= '0;
      a_q    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      // An aborted frame never reports done; an empty frame reports done at once.
      done_q <= frame_start ? (dst_h == '0) : (hs && last);
      if (start_run) begin
        step_q <= step;
        src_q  <= src_h;
        dst_q  <= dst_h;
        a_q    <= a_cfg;
        acc    <= acc_init;
        cnt    <= '0;
      end else if (!frame_start && hs && !last) begin
        acc <= acc + step_ext;
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Output fields derive only from registered state.
  logic signed [ACC_W-1:0] ipos;
  logic signed [ACC_W-1:0] hi;

  assign ipos = acc[ACC_W-1] ? '0 : (acc >>> 8);
  assign hi   = (src_q == '0) ? '0 : ACC_W'(src_q - 1'b1);

  function automatic logic [ROW_W-1:0] clamp(input logic signed [ACC_W-1:0] v,
                                             input logic signed [ACC_W-1:0] top);
    if (v < 0)        return '0;
    else if (v > top) return top[ROW_W-1:0];
    else              return v[ROW_W-1:0];
  endfunction

  assign row_valid  = (state == RUN);
  assign yBlend     = acc[ACC_W-1] ? 9'd0 : {1'b0, acc[7:0]};
  assign tap_m1     = clamp(ipos - ONE, hi);
  assign tap_0      = clamp(ipos, hi);
  assign tap_p1     = clamp(ipos + ONE, hi);
  assign tap_p2     = clamp(ipos + TWO, hi);
  assign coeffOne   = 9'd256;
  assign coeffHalf  = 9'd128;
  assign bi_a       = a_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_bicubic_y_coord_gen.sv
// Randomized + directed bench for bicubic_y_coord_gen against a row-list model.
module tb_bicubic_y_coord_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic [18:0] step;
  logic [10:0] src_h, dst_h;
  logic [8:0]  a_cfg;
  logic        row_valid, row_ready;
  logic [8:0]  yBlend, coeffOne, coeffHalf, bi_a;
  logic [10:0] tap_m1, tap_0, tap_p1, tap_p2;
  logic        frame_done;

  always #5 clk = ~clk;

  bicubic_y_coord_gen dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .step(step),
    .src_h(src_h), .dst_h(dst_h), .a_cfg(a_cfg), .row_valid(row_valid),
    .row_ready(row_ready), .yBlend(yBlend), .tap_m1(tap_m1), .tap_0(tap_0),
    .tap_p1(tap_p1), .tap_p2(tap_p2), .coeffOne(coeffOne), .coeffHalf(coeffHalf),
    .bi_a(bi_a), .frame_done(frame_done)
  );

  typedef struct {int t; int tap[4];} row_t;
  row_t q[$];
  bit   exp_done;
  int   exp_bi;
  int   n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Whole frame's expected rows, from the arithmetic position of each output row.
  function automatic void build_frame(int st, int sh, int dh);
    q.delete();
    for (int i = 0; i < dh; i++) begin
      longint pos = longint'(st / 2) - 128 + longint'(i) * st;
      int ip, t;
      row_t r;
      if (pos < 0) begin ip = 0; t = 0; end
      else begin ip = int'(pos / 256); t = int'(pos % 256); end
      r.t = t;
      for (int k = 0; k < 4; k++) begin
        int v = ip - 1 + k;
        r.tap[k] = (v < 0) ? 0 : (v > sh - 1) ? sh - 1 : v;
      end
      q.push_back(r);
    end
  endfunction

  // Called at negedge: check current outputs, drive inputs, advance model one edge.
  task automatic cycle(input bit fs, input bit rdy);
    chk("valid", row_valid, q.size() > 0);
    chk("done", frame_done, exp_done);
    chk("bi_a", bi_a, exp_bi);
    chk("coeffOne", coeffOne, 256);
    chk("coeffHalf", coeffHalf, 128);
    if (row_valid && q.size() > 0) begin
      chk("yBlend", yBlend, q[0].t);
      chk("tap_m1", tap_m1, q[0].tap[0]);
      chk("tap_0", tap_0, q[0].tap[1]);
      chk("tap_p1", tap_p1, q[0].tap[2]);
      chk("tap_p2", tap_p2, q[0].tap[3]);
    end
    frame_start = fs;
    row_ready   = rdy;
    exp_done    = 0;
    if (fs) begin
      build_frame(int'(step), int'(src_h), int'(dst_h));
      if (dst_h == 0) exp_done = 1;
      else exp_bi = int'(a_cfg);
    end else if (q.size() > 0 && rdy) begin
      void'(q.pop_front());
      if (q.size() == 0) exp_done = 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; frame_start = 0; row_ready = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid", row_valid, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_yBlend", yBlend, 0);
    chk("rst_taps", {tap_m1, tap_0, tap_p1, tap_p2}, 0);
    chk("rst_bi_a", bi_a, 0);
    chk("rst_coeffOne", coeffOne, 256);
    chk("rst_coeffHalf", coeffHalf, 128);
    rst = 0;
    q.delete(); exp_done = 0; exp_bi = 0;
  endtask

  task automatic cfg(input int st, input int sh, input int dh, input int a);
    step = 19'(st); src_h = 11'(sh); dst_h = 11'(dh); a_cfg = 9'(a);
  endtask

  initial begin
    cfg(0, 1, 0, 0);
    @(negedge clk);
    do_reset();

    // identity, full throughput
    cfg(256, 4, 4, 128); cycle(1, 1);
    repeat (6) cycle(0, 1);
    // identity with 3-cycle stall at row 1
    cycle(1, 1); cycle(0, 1);
    repeat (3) cycle(0, 0);
    repeat (6) cycle(0, 1);
    // 2x upscale
    cfg(128, 2, 4, 64); cycle(1, 1);
    repeat (6) cycle(0, 1);
    // downscale
    cfg(512, 8, 4, 200); cycle(1, 1);
    repeat (6) cycle(0, 1);
    // restart at row 2 together with a handshake
    cfg(256, 4, 4, 10); cycle(1, 1);
    cycle(0, 1); cycle(0, 1);
    cfg(128, 2, 4, 20); cycle(1, 1);
    repeat (6) cycle(0, 1);
    // reset mid-frame
    cfg(512, 8, 4, 99); cycle(1, 1);
    cycle(0, 1);
    do_reset();
    // empty frame, then bi_a hold while a_cfg wanders
    cfg(256, 4, 0, 77); cycle(1, 0);
    repeat (3) cycle(0, 1);
    cfg(256, 4, 4, 128); cycle(1, 0);
    a_cfg = 9'd5; cycle(0, 1);
    a_cfg = 9'd300; repeat (5) cycle(0, 1);

    // random frames, random backpressure, random restarts
    for (int i = 0; i < 1500; i++) begin
      bit fs = ($urandom % 20) == 0;
      if (fs) cfg($urandom_range(1, 2047), $urandom_range(1, 40),
                  $urandom_range(0, 15), $urandom_range(0, 511));
      else a_cfg = 9'($urandom);
      cycle(fs, ($urandom % 4) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
